// File: rtl/ro_sweep_ctrl.sv
// Ring-oscillator sweep sequencer: enables one ring at a time, counts its edges over a gate window
// and reports each count over a valid/ready handshake. Optional min/max tracking under RO_MINMAX_EN.
module ro_sweep_ctrl #(
    parameter int NUM_RO     = 3,
    parameter int CNT_W      = 16,
    parameter int GATE_CYC   = 1024,
    parameter int SETTLE_CYC = 8,
    localparam int CH_W      = (NUM_RO > 1) ? $clog2(NUM_RO) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_RO-1:0] ch_mask,
    input  logic [NUM_RO-1:0] ro_clk_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_count,
    output logic              sweep_done
`ifdef RO_MINMAX_EN
    ,
    output logic [CNT_W-1:0]  min_count,
    output logic [CNT_W-1:0]  max_count,
    output logic [CH_W-1:0]   min_ch,
    output logic [CH_W-1:0]   max_ch
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_GATE   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CYC_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYC - 1);
    localparam logic [CYC_W-1:0] DRAIN_LAST  = CYC_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [2:0]        state_r;
    logic [CYC_W-1:0]  cyc_r;
    logic [NUM_RO-1:0] mask_r;
    logic [CH_W-1:0]   ch_r;
    logic [CNT_W-1:0]  count_r;
    logic [NUM_RO-1:0] ro_en_r;
    logic              busy_r;
    logic              res_valid_r;
    logic [CH_W-1:0]   res_ch_r;
    logic [CNT_W-1:0]  res_count_r;
    logic              sweep_done_r;

    logic [NUM_RO-1:0] s1_r;
    logic [NUM_RO-1:0] s2_r;
    logic [NUM_RO-1:0] s3_r;
    logic [NUM_RO-1:0] edge_pulse_s;
    logic              edge_sel_s;
    logic [NUM_RO-1:0] remaining_s;
    logic              accept_start_s;
    logic              handshake_s;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_RO-1:0] m);
        logic [CH_W-1:0] idx;
        idx = {CH_W{1'b0}};
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            idx = m[i] ? CH_W'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [NUM_RO-1:0] ch_onehot(input logic [CH_W-1:0] c);
        return NUM_RO'(1'b1) << c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1'b1);
    endfunction

    assign edge_pulse_s   = s2_r & ~s3_r;
    assign edge_sel_s     = edge_pulse_s[ch_r];
    assign remaining_s    = mask_r & ~ch_onehot(ch_r);
    assign accept_start_s = (state_r == ST_IDLE) && start;
    assign handshake_s    = (state_r == ST_REPORT) && res_ready;

    // Synchronizer plus edge register for every ring, free-running in all states
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= {NUM_RO{1'b0}};
            s2_r <= {NUM_RO{1'b0}};
            s3_r <= {NUM_RO{1'b0}};
        end else begin
            s1_r <= ro_clk_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Sweep sequencer; every output is registered and ro_en only ever loads a one-hot or zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cyc_r        <= {CYC_W{1'b0}};
            mask_r       <= {NUM_RO{1'b0}};
            ch_r         <= {CH_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            ro_en_r      <= {NUM_RO{1'b0}};
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_ch_r     <= {CH_W{1'b0}};
            res_count_r  <= {CNT_W{1'b0}};
            sweep_done_r <= 1'b0;
        end else begin
            sweep_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r <= 1'b1;
                        cyc_r  <= {CYC_W{1'b0}};
                        if (ch_mask != {NUM_RO{1'b0}}) begin
                            mask_r  <= ch_mask;
                            ch_r    <= lowest_ch(ch_mask);
                            ro_en_r <= ch_onehot(lowest_ch(ch_mask));
                            state_r <= ST_SETTLE;
                        end else begin
                            mask_r  <= {NUM_RO{1'b0}};
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    count_r <= {CNT_W{1'b0}};
                    if (cyc_r == SETTLE_LAST) begin
                        cyc_r   <= {CYC_W{1'b0}};
                        state_r <= ST_GATE;
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1'b1);
                    end
                end
                ST_GATE: begin
                    if (edge_sel_s) begin
                        count_r <= sat_inc(count_r);
                    end else begin
                        count_r <= count_r;
                    end
                    if (cyc_r == GATE_LAST) begin
                        cyc_r   <= {CYC_W{1'b0}};
                        ro_en_r <= {NUM_RO{1'b0}};
                        state_r <= ST_DRAIN;
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1'b1);
                    end
                end
                ST_DRAIN: begin
                    // Three idle cycles let the last ring edges fall out of the synchronizer
                    if (cyc_r == DRAIN_LAST) begin
                        cyc_r       <= {CYC_W{1'b0}};
                        res_valid_r <= 1'b1;
                        res_ch_r    <= ch_r;
                        res_count_r <= count_r;
                        state_r     <= ST_REPORT;
                    end else begin
                        cyc_r <= cyc_r + CYC_W'(1'b1);
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        mask_r      <= remaining_s;
                        if (remaining_s != {NUM_RO{1'b0}}) begin
                            ch_r    <= lowest_ch(remaining_s);
                            ro_en_r <= ch_onehot(lowest_ch(remaining_s));
                            state_r <= ST_SETTLE;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_REPORT;
                    end
                end
                ST_DONE: begin
                    sweep_done_r <= 1'b1;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ro_en_r     <= {NUM_RO{1'b0}};
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ro_en      = ro_en_r;
    assign busy       = busy_r;
    assign res_valid  = res_valid_r;
    assign res_ch     = res_ch_r;
    assign res_count  = res_count_r;
    assign sweep_done = sweep_done_r;

`ifdef RO_MINMAX_EN
    logic [CNT_W-1:0] min_count_r;
    logic [CNT_W-1:0] max_count_r;
    logic [CH_W-1:0]  min_ch_r;
    logic [CH_W-1:0]  max_ch_r;

    // Running extremes; strict compares keep the earlier (lower) channel on ties
    always_ff @(posedge clk) begin
        if (reset) begin
            min_count_r <= {CNT_W{1'b0}};
            max_count_r <= {CNT_W{1'b0}};
            min_ch_r    <= {CH_W{1'b0}};
            max_ch_r    <= {CH_W{1'b0}};
        end else if (accept_start_s) begin
            min_count_r <= CNT_MAX;
            max_count_r <= {CNT_W{1'b0}};
            min_ch_r    <= {CH_W{1'b0}};
            max_ch_r    <= {CH_W{1'b0}};
        end else if (handshake_s) begin
            if (res_count_r < min_count_r) begin
                min_count_r <= res_count_r;
                min_ch_r    <= res_ch_r;
            end else begin
                min_count_r <= min_count_r;
            end
            if (res_count_r > max_count_r) begin
                max_count_r <= res_count_r;
                max_ch_r    <= res_ch_r;
            end else begin
                max_count_r <= max_count_r;
            end
        end else begin
            min_count_r <= min_count_r;
        end
    end

    assign min_count = min_count_r;
    assign max_count = max_count_r;
    assign min_ch    = min_ch_r;
    assign max_ch    = max_ch_r;
`else
    logic unused_s;
    assign unused_s = accept_start_s ^ handshake_s;
`endif

endmodule
